// File: rtl/mux_stream_nto1_pkg.sv
// mux_stream_nto1_pkg
// Shared definitions for the N-to-1 stream multiplexer slice.
//   clog2()      : width helper for select / channel tags, never below 1.
//   MODE_FIXED   : mode encoding for externally driven select.
//   MODE_RR      : mode encoding for internal round-robin arbitration.
//   out_state_t  : EMPTY/FULL state of the one-entry output stage.
package mux_stream_nto1_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  // Width of an index able to address n items; a single channel still
  // gets a 1-bit tag so that ports never collapse to zero width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_stream_nto1_rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter: holds the rotating priority pointer and finds the
// first requesting channel at or above it, wrapping from N-1 to 0.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : per-channel request (in_valid of the producers)
//   advance     : move the pointer past the current grant this cycle
//   grant       : index of the granted channel
//   grant_valid : at least one request is present
module rr_arbiter
  import mux_stream_nto1_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [SELW-1:0] grant,
  output logic            grant_valid
);

  logic [SELW-1:0] rr_ptr;

  // Scan offsets from highest to lowest so the smallest offset from the
  // pointer is the one left standing, giving the first requester at or
  // after rr_ptr without needing an early exit from the loop.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      if (req[(int'(rr_ptr) + off) % N]) begin
        grant       = SELW'((int'(rr_ptr) + off) % N);
        grant_valid = 1'b1;
      end
    end
  end

  // The pointer moves to the channel after the one just served, so that
  // channel has the lowest priority on the next search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (advance && grant_valid) begin
      rr_ptr <= (int'(grant) == N - 1) ? '0 : grant + 1'b1;
    end
  end

endmodule

// File: rtl/mux_stream_nto1.sv
// mux_stream_nto1
// N-to-1 valid/ready stream multiplexer with a one-entry registered output.
// Channel choice comes from sel (fixed mode) or a round-robin arbiter.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_data  [N*W]      : channel i in bits [i*W +: W]
//   in_valid [N]        : per-channel valid
//   in_ready [N]        : per-channel ready (combinational)
//   mode                : MODE_FIXED or MODE_RR
//   sel      [SELW]     : channel used in fixed mode
//   out_data [W]        : registered data
//   out_valid           : registered valid
//   out_chan [SELW]     : registered source channel of out_data
//   out_ready           : downstream ready
module mux_stream_nto1
  import mux_stream_nto1_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int W    = 8,
  localparam int SELW = clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  output logic [SELW-1:0] out_chan,
  input  logic            out_ready
);

  out_state_t      state;
  logic [1:0]      rst_sync;
  logic            run;
  logic [SELW-1:0] rr_grant;
  logic            rr_grant_valid;
  logic [SELW-1:0] grant;
  logic            grant_valid;
  logic            can_load;
  logic            xfer;
  logic [W-1:0]    grant_data;

  // Reset assertion clears this pair immediately; release ripples through
  // two clock edges, so loading only resumes on a clean, clock-aligned
  // boundary and in_ready is forced low throughout reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run = rst_sync[1];

  rr_arbiter #(
    .N (N)
  ) u_rr_arbiter (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (in_valid),
    .advance     (xfer && (mode == MODE_RR)),
    .grant       (rr_grant),
    .grant_valid (rr_grant_valid)
  );

  // Fixed mode grants sel regardless of its valid bit; an out-of-range sel
  // (only possible when N is not a power of two) grants nothing.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (mode == MODE_RR) begin
      grant       = rr_grant;
      grant_valid = rr_grant_valid;
    end else if (int'(sel) < N) begin
      grant       = sel;
      grant_valid = 1'b1;
    end
  end

  assign can_load   = run && ((state == ST_EMPTY) || out_ready);
  assign grant_data = in_data[int'(grant) * W +: W];
  assign xfer       = grant_valid && can_load && in_valid[grant];

  always_comb begin
    in_ready = '0;
    if (grant_valid && can_load) begin
      in_ready[grant] = 1'b1;
    end
  end

  // A load always wins over a drain: when both happen at the same edge the
  // entry is simply replaced and the stage stays FULL. A drain alone only
  // clears the state; data and channel tag are left untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      out_chan <= '0;
    end else if (xfer) begin
      state    <= ST_FULL;
      out_data <= grant_data;
      out_chan <= grant;
    end else if ((state == ST_FULL) && out_ready) begin
      state    <= ST_EMPTY;
    end
  end

  assign out_valid = (state == ST_FULL);

endmodule

// File: tb/tb_mux_stream_nto1.sv
// tb_mux_stream_nto1
// Self-checking bench for mux_stream_nto1 (N=4, W=8): directed scenarios
// plus a randomized run, all compared with a transaction-level model.
module tb_mux_stream_nto1;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int SELW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic            mode;
  logic [SELW-1:0] sel;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic [SELW-1:0] out_chan;
  logic            out_ready;

  int tests  = 0;
  int failed = 0;

  // Reference model state: the single output entry and the rotating pointer.
  bit              m_full;
  logic [W-1:0]    m_data;
  logic [SELW-1:0] m_chan;
  int              m_ptr;

  // Decision taken for the upcoming edge.
  bit              p_xfer;
  bit              p_drain;
  int              p_g;
  logic [W-1:0]    p_data;

  mux_stream_nto1 #(
    .N (N),
    .W (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Grant by rule: fixed mode takes sel, round-robin takes the lowest valid
  // channel numbered at or above the pointer, else the lowest valid overall.
  function automatic int model_grant();
    int cand[$];
    if (mode == 1'b0) begin
      return (int'(sel) < N) ? int'(sel) : -1;
    end
    for (int c = 0; c < N; c++) begin
      if (in_valid[c]) cand.push_back(c);
    end
    if (cand.size() == 0) return -1;
    foreach (cand[k]) begin
      if (cand[k] >= m_ptr) return cand[k];
    end
    return cand[0];
  endfunction

  task automatic model_reset();
    m_full = 1'b0;
    m_data = '0;
    m_chan = '0;
    m_ptr  = 0;
  endtask

  task automatic set_chan(input int c, input logic [W-1:0] v);
    in_data[c*W +: W] = v;
  endtask

  // Settle inputs, then work out what the coming edge should do.
  task automatic predict(output logic [N-1:0] er);
    bit can_load;
    #1;
    p_g      = model_grant();
    can_load = !m_full || out_ready;
    er       = '0;
    p_xfer   = 1'b0;
    p_data   = '0;
    if (p_g >= 0) begin
      if (can_load) er[p_g] = 1'b1;
      p_xfer = can_load && in_valid[p_g];
      p_data = in_data[p_g*W +: W];
    end
    p_drain = m_full && out_ready;
  endtask

  task automatic tick();
    @(posedge clk);
    if (p_xfer) begin
      m_full = 1'b1;
      m_data = p_data;
      m_chan = SELW'(p_g);
      if (mode == 1'b1) m_ptr = (p_g + 1) % N;
    end else if (p_drain) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  task automatic release_reset();
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic applyStimulus(input logic md, input logic [SELW-1:0] s,
                               input logic [N-1:0] v, input logic ordy);
    mode      = md;
    sel       = s;
    in_valid  = v;
    out_ready = ordy;
  endtask

  task automatic test_reset();
    logic [N-1:0] er;
    rst_n   = 1'b0;
    in_data = {$urandom, $urandom};
    applyStimulus(1'b1, '0, 4'b1111, 1'b1);
    @(posedge clk);
    #1;
    tests++; if (out_valid !== 1'b0) begin failed++; $display("[TB] FAIL reset_out_valid got %b expected 0", out_valid); end
    tests++; if (out_data !== 8'h00) begin failed++; $display("[TB] FAIL reset_out_data got %h expected 00", out_data); end
    tests++; if (in_ready !== 4'b0000) begin failed++; $display("[TB] FAIL reset_in_ready got %b expected 0000", in_ready); end
    release_reset();
    in_valid = 4'b1111;
    predict(er);
    tests++; if (in_ready !== 4'b0001) begin failed++; $display("[TB] FAIL first_grant_ready got %b expected 0001", in_ready); end
    tick();
    tests++; if (out_valid !== 1'b1 || out_chan !== 2'd0) begin failed++; $display("[TB] FAIL first_grant_chan got %b/%0d expected 1/0", out_valid, out_chan); end
  endtask

  task automatic test_fixed();
    logic [N-1:0] er;
    set_chan(2, 8'hA5);
    applyStimulus(1'b0, 2'd2, 4'b0100, 1'b1);
    predict(er);
    tests++; if (in_ready !== 4'b0100) begin failed++; $display("[TB] FAIL fixed_ready got %b expected 0100", in_ready); end
    tick();
    tests++; if (out_data !== 8'hA5 || out_chan !== 2'd2 || out_valid !== 1'b1) begin failed++; $display("[TB] FAIL fixed_out got %h/%0d/%b expected a5/2/1", out_data, out_chan, out_valid); end
    set_chan(1, 8'h3C);
    applyStimulus(1'b0, 2'd1, 4'b0010, 1'b1);
    predict(er);
    tests++; if (in_ready !== er) begin failed++; $display("[TB] FAIL fixed_sel1_ready got %b expected %b", in_ready, er); end
    tick();
    tests++; if (out_chan !== 2'd1 || out_data !== 8'h3C) begin failed++; $display("[TB] FAIL fixed_sel1_out got %0d/%h expected 1/3c", out_chan, out_data); end
  endtask

  task automatic test_rr_order();
    logic [N-1:0] er;
    int start;
    for (int c = 0; c < N; c++) set_chan(c, 8'(8'h10 + c));
    applyStimulus(1'b1, 2'd3, 4'b1111, 1'b1);
    start = m_ptr;
    for (int i = 0; i < 8; i++) begin
      predict(er);
      tests++; if (in_ready !== er) begin failed++; $display("[TB] FAIL rr_order_ready[%0d] got %b expected %b", i, in_ready, er); end
      tick();
      tests++; if (out_chan !== SELW'((start + i) % N) || out_data !== 8'(8'h10 + (start + i) % N)) begin
        failed++; $display("[TB] FAIL rr_order_beat[%0d] got %0d/%h expected %0d/%h", i, out_chan, out_data, (start + i) % N, 8'h10 + (start + i) % N);
      end
    end
  endtask

  task automatic test_rr_skip();
    logic [N-1:0] er;
    logic [SELW-1:0] prev;
    applyStimulus(1'b1, 2'd0, 4'b1010, 1'b1);
    prev = 2'd0;
    for (int i = 0; i < 4; i++) begin
      predict(er);
      tests++; if (in_ready !== er) begin failed++; $display("[TB] FAIL rr_skip_ready[%0d] got %b expected %b", i, in_ready, er); end
      tick();
      tests++; if (out_chan !== m_chan || (i > 0 && out_chan === prev) || (out_chan !== 2'd1 && out_chan !== 2'd3)) begin
        failed++; $display("[TB] FAIL rr_skip_chan[%0d] got %0d expected %0d", i, out_chan, m_chan);
      end
      prev = out_chan;
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] er;
    set_chan(3, 8'h5A);
    applyStimulus(1'b0, 2'd3, 4'b1000, 1'b1);
    predict(er);
    tick();
    tests++; if (out_data !== 8'h5A || out_valid !== 1'b1) begin failed++; $display("[TB] FAIL bp_load got %h/%b expected 5a/1", out_data, out_valid); end
    set_chan(3, 8'h77);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      predict(er);
      tests++; if (in_ready !== 4'b0000) begin failed++; $display("[TB] FAIL bp_ready[%0d] got %b expected 0000", i, in_ready); end
      tick();
      tests++; if (out_data !== 8'h5A || out_valid !== 1'b1 || out_chan !== 2'd3) begin failed++; $display("[TB] FAIL bp_hold[%0d] got %h/%b expected 5a/1", i, out_data, out_valid); end
    end
    out_ready = 1'b1;
    predict(er);
    tests++; if (in_ready !== 4'b1000) begin failed++; $display("[TB] FAIL bp_release_ready got %b expected 1000", in_ready); end
    tick();
    tests++; if (out_data !== 8'h77 || out_valid !== 1'b1) begin failed++; $display("[TB] FAIL bp_next got %h/%b expected 77/1", out_data, out_valid); end
    in_valid = 4'b0000;
    predict(er);
    tick();
    tests++; if (out_valid !== 1'b0 || out_data !== 8'h77) begin failed++; $display("[TB] FAIL bp_drain got %b/%h expected 0/77", out_valid, out_data); end
  endtask

  task automatic test_async_reset();
    logic [N-1:0] er;
    applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
    repeat (2) begin
      predict(er);
      tick();
    end
    out_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin failed++; $display("[TB] FAIL async_out_valid got %b expected 0", out_valid); end
    tests++; if (in_ready !== 4'b0000) begin failed++; $display("[TB] FAIL async_in_ready got %b expected 0000", in_ready); end
    release_reset();
    applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
    predict(er);
    tests++; if (in_ready !== 4'b0001) begin failed++; $display("[TB] FAIL async_ptr_ready got %b expected 0001", in_ready); end
    tick();
    tests++; if (out_chan !== 2'd0 || out_valid !== 1'b1) begin failed++; $display("[TB] FAIL async_ptr_chan got %0d/%b expected 0/1", out_chan, out_valid); end
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    for (int i = 0; i < 400; i++) begin
      in_data = {$urandom, $urandom};
      applyStimulus(1'($urandom_range(0, 1)), SELW'($urandom_range(0, N - 1)),
                    N'($urandom), ($urandom_range(0, 3) != 0));
      predict(er);
      tests++; if (in_ready !== er) begin failed++; $display("[TB] FAIL rand_ready[%0d] got %b expected %b", i, in_ready, er); end
      tick();
      tests++; if (out_valid !== m_full || out_data !== m_data || out_chan !== m_chan) begin
        failed++; $display("[TB] FAIL rand_out[%0d] got %b/%h/%0d expected %b/%h/%0d", i, out_valid, out_data, out_chan, m_full, m_data, m_chan);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fixed();
    test_rr_order();
    test_rr_skip();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
